// File: rtl/spawn_pkg.sv
// Shared types for the enemy spawn controller.
// Holds the FSM state enum and the lane geometry constants.
package spawn_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_CHECK,
    S_SCAN,
    S_OFFER
  } state_t;

endpackage

// File: rtl/lane_pick.sv
// Lowest-index free lane priority encoder.
// Ports: i_busy (lane occupied flags), o_lane (lowest free), o_all_busy.
module lane_pick
  import spawn_pkg::*;
(
  input  logic [NUM_LANES-1:0] i_busy,
  output logic [LANE_W-1:0]    o_lane,
  output logic                 o_all_busy
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    o_lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (!i_busy[i]) o_lane = LANE_W'(i);
    end
  end

  assign o_all_busy = &i_busy;

endmodule

// File: rtl/spawn_ctrl.sv
// Periodic enemy spawner: random lane draw with retries, fallback scan,
// valid/ack offer of lane + Y, and live enemy bookkeeping.
// Ports: clk, resetN, enable, startOfFrame, rand_req/rand_in, slot_busy,
// enemy_killed, spawn_valid/lane/y, spawn_ack, live_count.
module spawn_ctrl
  import spawn_pkg::*;
#(
  parameter int PERIOD_FRAMES = 120,
  parameter int MAX_ENEMIES   = 4,
  parameter int MAX_RETRY     = 3,
  parameter int LANE_BASE     = 32,
  parameter int LANE_PITCH    = 96
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 enable,
  input  logic                 startOfFrame,
  output logic                 rand_req,
  input  logic [LANE_W-1:0]    rand_in,
  input  logic [NUM_LANES-1:0] slot_busy,
  input  logic                 enemy_killed,
  output logic                 spawn_valid,
  output logic [LANE_W-1:0]    spawn_lane,
  output logic [10:0]          spawn_y,
  input  logic                 spawn_ack,
  output logic [2:0]           live_count
);

  localparam int FW = (PERIOD_FRAMES < 1) ? 1
                    : $clog2(PERIOD_FRAMES + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1
                    : $clog2(MAX_RETRY + 1);

  localparam logic [FW-1:0] PER  = FW'(PERIOD_FRAMES);
  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRY);
  localparam logic [2:0]    MAXL = 3'(MAX_ENEMIES);

  state_t              r_state;
  state_t              w_state_next;
  logic [FW-1:0]       r_frame_cnt;
  logic [RW-1:0]       r_retry;
  logic [LANE_W-1:0]   r_lane;
  logic [10:0]         r_y;
  logic [2:0]          r_live;
  logic [2:0]          w_live_next;
  logic                w_acc;
  logic                w_rand_busy;
  logic [LANE_W-1:0]   w_pick_lane;
  logic                w_all_busy;
  logic [LANE_W-1:0]   w_sel_lane;
  logic [10:0]         w_sel_y;
  logic                w_enter_wait;
  logic                w_enter_offer;

  lane_pick u_pick (
    .i_busy     (slot_busy),
    .o_lane     (w_pick_lane),
    .o_all_busy (w_all_busy)
  );

  assign w_acc       = (r_state == S_OFFER) && spawn_ack;
  assign w_rand_busy = slot_busy[rand_in];
  assign w_sel_lane  = (r_state == S_CHECK) ? rand_in
                                             : w_pick_lane;
  assign w_sel_y     = 11'(LANE_BASE
                     + int'(w_sel_lane) * LANE_PITCH);

  assign w_enter_wait  = (w_state_next == S_WAIT)
                      && (r_state != S_WAIT);
  assign w_enter_offer = (w_state_next == S_OFFER)
                      && (r_state != S_OFFER);

  // Accept and kill in the same cycle cancel out.
  always_comb begin
    w_live_next = r_live;
    case ({w_acc, enemy_killed})
      2'b10: if (r_live < MAXL) w_live_next = r_live + 3'd1;
      2'b01: if (r_live != 3'd0) w_live_next = r_live - 3'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // The live check uses next-cycle count so a kill releases the
  // held period straight into REQ.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (enable) w_state_next = S_WAIT;
      S_WAIT:
        if (!enable) w_state_next = S_IDLE;
        else if (r_frame_cnt >= PER && w_live_next < MAXL)
          w_state_next = S_REQ;
      S_REQ:
        w_state_next = enable ? S_CHECK : S_IDLE;
      S_CHECK:
        if (!enable) w_state_next = S_IDLE;
        else if (!w_rand_busy) w_state_next = S_OFFER;
        else if (r_retry < MAXR) w_state_next = S_REQ;
        else w_state_next = S_SCAN;
      S_SCAN:
        if (!enable) w_state_next = S_IDLE;
        else if (w_all_busy) w_state_next = S_WAIT;
        else w_state_next = S_OFFER;
      S_OFFER:
        if (spawn_ack)
          w_state_next = enable ? S_WAIT : S_IDLE;
      default:
        w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rand_req    = (r_state == S_REQ);
    spawn_valid = (r_state == S_OFFER);
    spawn_lane  = r_lane;
    spawn_y     = r_y;
    live_count  = r_live;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frame_cnt <= '0;
      r_retry     <= '0;
    end else if (w_enter_wait) begin
      r_frame_cnt <= '0;
      r_retry     <= '0;
    end else begin
      if (r_state == S_WAIT && startOfFrame
          && r_frame_cnt < PER)
        r_frame_cnt <= r_frame_cnt + 1'b1;
      if (r_state == S_CHECK && w_state_next == S_REQ)
        r_retry <= r_retry + 1'b1;
    end
  end

  // Offer payload is latched once on entry and held until accepted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_lane <= '0;
      r_y    <= '0;
    end else if (w_enter_offer) begin
      r_lane <= w_sel_lane;
      r_y    <= w_sel_y;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_live <= '0;
    else         r_live <= w_live_next;
  end

endmodule

// File: tb/tb_spawn_ctrl.sv
// Directed self-checking bench for spawn_ctrl.
// Table of spawn attempts plus hand sequences for timing corners.
module tb_spawn_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        enable = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        rand_req;
  logic [1:0]  rand_in = 2'd0;
  logic [3:0]  slot_busy = 4'd0;
  logic        enemy_killed = 1'b0;
  logic        spawn_valid;
  logic [1:0]  spawn_lane;
  logic [10:0] spawn_y;
  logic        spawn_ack = 1'b0;
  logic [2:0]  live_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spawn_ctrl #(.PERIOD_FRAMES(2)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .enable       (enable),
    .startOfFrame (startOfFrame),
    .rand_req     (rand_req),
    .rand_in      (rand_in),
    .slot_busy    (slot_busy),
    .enemy_killed (enemy_killed),
    .spawn_valid  (spawn_valid),
    .spawn_lane   (spawn_lane),
    .spawn_y      (spawn_y),
    .spawn_ack    (spawn_ack),
    .live_count   (live_count)
  );

  typedef struct {
    logic [1:0] rnd;
    logic [3:0] busy;
    int         lane;
    int         y;
    int         pulses;
  } vec_t;

  vec_t tbl[5];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
  endtask

  task automatic run_to_offer(output int pulses,
                              output int ok);
    pulses = 0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      startOfFrame = (i % 3 == 1);
      if (rand_req) pulses++;
      if (spawn_valid) begin
        ok = 1;
        break;
      end
      cyc();
    end
    startOfFrame = 1'b0;
  endtask

  task automatic accept();
    spawn_ack = 1'b1;
    cyc();
    spawn_ack = 1'b0;
  endtask

  task automatic count_idle(input int n, output int reqs,
                            output int vals);
    reqs = 0;
    vals = 0;
    for (int i = 0; i < n; i++) begin
      if (rand_req) reqs++;
      if (spawn_valid) vals++;
      cyc();
    end
  endtask

  int p, ok, r, v;

  initial begin
    tbl[0] = '{2'd2, 4'b0000, 2, 224, 1};
    tbl[1] = '{2'd1, 4'b0110, 0, 32, 4};
    tbl[2] = '{2'd3, 4'b0000, 3, 320, 1};
    tbl[3] = '{2'd0, 4'b0001, 1, 128, 4};
    tbl[4] = '{2'd2, 4'b1011, 2, 224, 1};

    // reset state
    cyc(); cyc();
    chk("rst_valid", spawn_valid, 0);
    chk("rst_req", rand_req, 0);
    chk("rst_lane", spawn_lane, 0);
    chk("rst_y", spawn_y, 0);
    chk("rst_live", live_count, 0);

    // first attempt timing, PERIOD_FRAMES=2
    resetN = 1'b1;
    enable = 1'b1;
    rand_in = 2'd2;
    cyc();
    cyc(); cyc();
    chk("req_noframe", rand_req, 0);
    sof_pulse();
    cyc(); cyc();
    chk("req_oneframe", rand_req, 0);
    sof_pulse();
    chk("req_early", rand_req, 0);
    cyc();
    chk("req_pulse", rand_req, 1);
    cyc();
    chk("req_one_cycle", rand_req, 0);
    cyc();
    chk("offer_valid", spawn_valid, 1);
    chk("offer_lane", spawn_lane, 2);
    chk("offer_y", spawn_y, 224);

    // offer held while ack withheld and slots change
    slot_busy = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold_offer",
          {spawn_valid, spawn_lane, spawn_y},
          {1'b1, 2'd2, 11'd224});
    end
    slot_busy = 4'b0000;
    accept();
    chk("ack_drop", spawn_valid, 0);
    chk("ack_live1", live_count, 1);

    // ack outside OFFER is ignored
    spawn_ack = 1'b1;
    cyc();
    spawn_ack = 1'b0;
    chk("stray_ack", live_count, 1);

    // second spawn, then simultaneous ack + kill at 2
    rand_in = 2'd0;
    run_to_offer(p, ok);
    chk("reach2", ok, 1);
    chk("lane2", spawn_lane, 0);
    accept();
    chk("live2", live_count, 2);
    run_to_offer(p, ok);
    chk("reach3", ok, 1);
    spawn_ack = 1'b1;
    enemy_killed = 1'b1;
    cyc();
    spawn_ack = 1'b0;
    enemy_killed = 1'b0;
    chk("ack_kill", live_count, 2);
    chk("ack_kill_drop", spawn_valid, 0);
    enemy_killed = 1'b1;
    cyc(); cyc(); cyc();
    enemy_killed = 1'b0;
    chk("kill_sat", live_count, 0);

    // table of spawn attempts
    for (int k = 0; k < 5; k++) begin
      rand_in = tbl[k].rnd;
      slot_busy = tbl[k].busy;
      run_to_offer(p, ok);
      chk("tbl_reach", ok, 1);
      chk("tbl_pulses", p, tbl[k].pulses);
      chk("tbl_lane", spawn_lane, tbl[k].lane);
      chk("tbl_y", spawn_y, tbl[k].y);
      accept();
      chk("tbl_live", live_count, 1);
      enemy_killed = 1'b1;
      cyc();
      enemy_killed = 1'b0;
      chk("tbl_kill", live_count, 0);
    end

    // all lanes busy: 4 draws, scan fails, back to waiting
    slot_busy = 4'b1111;
    rand_in = 2'd0;
    sof_pulse();
    cyc();
    sof_pulse();
    count_idle(30, r, v);
    chk("full_pulses", r, 4);
    chk("full_novalid", v, 0);
    sof_pulse();
    count_idle(3, r, v);
    chk("full_wait1", r, 0);
    sof_pulse();
    chk("full_wait2", rand_req, 0);
    cyc();
    chk("full_retry", rand_req, 1);
    count_idle(30, r, v);
    slot_busy = 4'b0000;

    // live count cap
    for (int k = 0; k < 4; k++) begin
      run_to_offer(p, ok);
      chk("fill_reach", ok, 1);
      accept();
    end
    chk("live_max", live_count, 4);
    sof_pulse();
    cyc();
    sof_pulse();
    count_idle(12, r, v);
    chk("cap_noreq", r, 0);
    enemy_killed = 1'b1;
    cyc();
    enemy_killed = 1'b0;
    chk("kill_req", rand_req, 1);
    chk("kill_live", live_count, 3);
    run_to_offer(p, ok);
    chk("cap_reach", ok, 1);
    accept();
    chk("cap_live4", live_count, 4);

    // enable low during OFFER: handshake completes first
    enemy_killed = 1'b1;
    cyc();
    enemy_killed = 1'b0;
    run_to_offer(p, ok);
    chk("dis_reach", ok, 1);
    enable = 1'b0;
    cyc(); cyc(); cyc();
    chk("dis_hold", spawn_valid, 1);
    accept();
    chk("dis_drop", spawn_valid, 0);
    chk("dis_live", live_count, 4);
    enemy_killed = 1'b1;
    cyc(); cyc();
    enemy_killed = 1'b0;
    chk("dis_kill", live_count, 2);
    sof_pulse();
    cyc();
    sof_pulse();
    count_idle(10, r, v);
    chk("idle_noreq", r, 0);

    // reset mid-OFFER
    enable = 1'b1;
    rand_in = 2'd3;
    run_to_offer(p, ok);
    chk("rst_reach", ok, 1);
    resetN = 1'b0;
    #1;
    chk("rsto_valid", spawn_valid, 0);
    chk("rsto_live", live_count, 0);
    chk("rsto_lane", spawn_lane, 0);
    chk("rsto_y", spawn_y, 0);
    chk("rsto_req", rand_req, 0);
    cyc();
    resetN = 1'b1;
    count_idle(5, r, v);
    chk("rsto_idle", r + v, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
